mem_bank_ctrl: RTL
==================

Name: mem_bank_ctrl

Overview:
- Parametrised single-port synchronous memory bank with a valid/ready request interface, byte-lane write enables and a registered read response.
- Memory is zeroed by a hardware clear sequencer, run after reset and on software request, one word per cycle.
- Intended as the general scratch/storage bank for data-wrangling pipelines; one request per cycle once clear completes.

Parameters:
- DW, 32, data word width in bits; must be a multiple of 8; elaboration error otherwise.
- DEPTH, 16, number of words; need not be a power of two.
- AW, $clog2(DEPTH) (min 1), address width.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  bank accepts request this cycle
- req_we  in  1  1=write, 0=read
- req_addr  in  AW  word address
- req_wdata  in  DW  write data
- req_be  in  DW/8  byte-lane write enables; bit i covers wdata[8i+7:8i]
- clr_start  in  1  pulse: request full-memory clear
- busy  out  1  clear sequence in progress
- rsp_valid  out  1  read data valid (1-cycle pulse per read)
- rsp_rdata  out  DW  read data
- parity_err  out  1  present only with MEM_PARITY_EN

Behaviour:
- Reset is synchronous, active-high. While reset is high: state=CLEAR, clear counter=0, busy=1, req_ready=0, rsp_valid=0, rsp_rdata=0, parity_err=0.
- FSM states:
  - CLEAR: writes 0 to word[cnt] each cycle, cnt++. Leaves for RUN on the cycle cnt==DEPTH-1 is written.
  - RUN: normal operation.
- Clear timing: after reset deasserts, busy stays high for exactly DEPTH cycles. req_ready=1 and busy=0 from cycle DEPTH after the reset release edge.
- req_ready = (state==RUN). A handshake occurs when req_valid && req_ready.
- Write handshake:
  - Only lanes with req_be[i]=1 are updated; other lanes keep their old value.
  - be=0 is a legal no-op.
  - No response is generated.
- Read handshake: rsp_valid=1 on the next cycle with rsp_rdata=word[addr]. Latency is exactly 1 cycle.
- rsp_rdata holds its last value when rsp_valid=0. It is not cleared by the clear sequence, only by reset.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data. No bypass is needed, since there is one op per cycle.
- Out-of-range address (addr>=DEPTH, non-power-of-2 DEPTH):
  - writes are ignored;
  - reads return 0 with rsp_valid=1.
- clr_start in RUN:
  - state goes to CLEAR next cycle, cnt=0, busy=1 next cycle.
  - A request handshaken in the same cycle as clr_start still executes. A write lands and is then cleared. A read returns pre-clear data next cycle.
- clr_start while in CLEAR is ignored; the sequence does not restart.
- Reset asserted mid-clear or mid-read: rsp_valid is forced 0 and the clear restarts from cnt=0 after release.
- Cycle budget: each clear costs exactly DEPTH cycles; no request is accepted during clear.

Optional Feature:
- Macro: MEM_PARITY_EN.
- Defined:
  - Each byte lane stores an extra even-parity bit, written with its lane; the clear sequence writes parity 0.
  - Adds input port err_inject (1 bit). When high on a write handshake, the stored parity of every written lane is inverted.
  - On each read response, parity is recomputed per lane. parity_err=1 in the same cycle as rsp_valid if any lane mismatches, else 0.
  - parity_err is 0 whenever rsp_valid=0.
  - Out-of-range reads report parity_err=0.
- Undefined: no parity storage, no err_inject or parity_err ports; behaviour otherwise identical.

Test Plan (DW=32, DEPTH=16 unless noted):
- Reset then release: busy=1 and req_ready=0 for 16 cycles, then req_ready=1 and busy=0. Read of every address returns 0x00000000 with rsp_valid exactly 1 cycle after each handshake.
- Write addr 3 = 0xDEADBEEF with be=4'hF, then write addr 3 = 0x11223344 with be=4'b0101, then read addr 3 -> rsp_rdata=0xDE22BE44.
- Back-to-back write addr 7 = 0xA5A5A5A5 (be=F) then read addr 7 the next cycle -> 0xA5A5A5A5 one cycle later. Continuous reads of addrs 0..15 give one rsp_valid per cycle.
- Read addr 5 handshaken in the same cycle as clr_start -> next cycle returns the old addr-5 data and busy=1. After 16 busy cycles, read addr 5 -> 0.
- Assert reset for 1 cycle at cnt=9 of a clear -> busy lasts a full 16 cycles after release. DEPTH=10: write addr 12 ignored, read addr 12 -> rsp_valid=1, data 0.
- MEM_PARITY_EN: write addr 2 = 0x000000FF with err_inject=1 -> read addr 2 gives parity_err=1 with rsp_valid. Rewrite with err_inject=0 and read -> parity_err=0.

Source files
------------

// File: rtl/mem_bank_ctrl.sv
// Single-port memory bank with valid/ready requests, byte-lane writes, 1-cycle read response
// and a one-word-per-cycle hardware clear. Define MEM_PARITY_EN for per-lane even parity.
module mem_bank_ctrl #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    input  logic [DW/8-1:0] req_be,
    input  logic            clr_start,
`ifdef MEM_PARITY_EN
    input  logic            err_inject,
    output logic            parity_err,
`endif
    output logic            busy,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_rdata
);
    localparam int NB = DW / 8;
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    generate
        if ((DW % 8) != 0 || DW == 0) begin : g_dw_chk
            $error("mem_bank_ctrl: DW must be a non-zero multiple of 8");
        end
    endgenerate

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [DW-1:0] mem_q [DEPTH];

    logic          hs, in_range, wr_en;
    logic [AW-1:0] wr_idx;
    logic [DW-1:0] wr_data, rd_word;

    // Power-of-two depth can never be addressed out of range.
    generate
        if (DEPTH == (2 ** AW)) begin : g_full
            assign in_range = 1'b1;
        end else begin : g_part
            assign in_range = (req_addr < AW'(DEPTH));
        end
    endgenerate

    assign req_ready = (state_q == ST_RUN) && !reset;
    assign busy      = (state_q == ST_CLEAR) || reset;
    assign hs        = req_valid && req_ready;
    assign rd_word   = in_range ? mem_q[req_addr] : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

`ifdef MEM_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];
    logic [NB-1:0] wr_par, rd_par;
    logic          parity_err_q, parity_err_d;

    function automatic logic [NB-1:0] lane_par(input logic [DW-1:0] w);
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) p[i] = ^w[8*i +: 8];
        return p;
    endfunction

    assign rd_par     = in_range ? par_q[req_addr] : '0;
    assign parity_err = parity_err_q;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        wr_en       = 1'b0;
        wr_idx      = req_addr;
        wr_data     = rd_word;
`ifdef MEM_PARITY_EN
        wr_par       = rd_par;
        parity_err_d = 1'b0;
`endif
        if (state_q == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_idx  = cnt_q;
            wr_data = '0;
`ifdef MEM_PARITY_EN
            wr_par  = '0;
`endif
            if (cnt_q == AW'(DEPTH - 1)) state_d = ST_RUN;
            else                         cnt_d   = cnt_q + 1'b1;
        end else begin
            // The request accepted alongside clr_start still completes.
            if (hs && req_we) begin
                wr_en = in_range;
                for (int i = 0; i < NB; i++) begin
                    if (req_be[i]) begin
                        wr_data[8*i +: 8] = req_wdata[8*i +: 8];
`ifdef MEM_PARITY_EN
                        wr_par[i] = (^req_wdata[8*i +: 8]) ^ err_inject;
`endif
                    end
                end
            end else if (hs) begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = rd_word;
`ifdef MEM_PARITY_EN
                parity_err_d = in_range && (lane_par(rd_word) != rd_par);
`endif
            end
            if (clr_start) begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        end
        if (reset) begin
            state_d     = ST_CLEAR;
            cnt_d       = '0;
            rsp_valid_d = 1'b0;
            rsp_rdata_d = '0;
            wr_en       = 1'b0;
`ifdef MEM_PARITY_EN
            parity_err_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        rsp_valid_q <= rsp_valid_d;
        rsp_rdata_q <= rsp_rdata_d;
        if (wr_en) mem_q[wr_idx] <= wr_data;
`ifdef MEM_PARITY_EN
        parity_err_q <= parity_err_d;
        if (wr_en) par_q[wr_idx] <= wr_par;
`endif
    end
endmodule
